md_dispatch: RTL and testbench
==============================

MD_DISPATCH -- requirements
Module: md_dispatch

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16, the maximum number of WAIT cycles before a timeout (used only with MD_DISPATCH_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  1  exception/interrupt flush; while high, the multiply-divide unit commits nothing.
REQ-005 SHALL have port in_valid  input  1  pipeline presents an MD operation.
REQ-006 SHALL have port in_op  input  4  operation code, fixed values: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mflo, 6 mfhi, 7 mtlo, 8 mthi.
REQ-007 SHALL have ports in_rs and in_rt  input  32 each  operands.
REQ-008 SHALL have port stall  output  1  pipeline must hold its MD instruction.
REQ-009 SHALL have port md_op  output  4  registered operation to the unit.
REQ-010 SHALL have ports md_rs and md_rt  output  32 each  registered operands to the unit.
REQ-011 SHALL have port md_busy  input  1  unit busy; high when the unit's counter is nonzero or md_op is a start op (codes 1-4).
REQ-012 SHALL have port md_out  input  32  unit HI/LO read data, combinational from md_op.
REQ-013 SHALL have port rd_data  output  32  captured mflo/mfhi result.
REQ-014 SHALL have port rd_valid  output  1  one-cycle pulse when rd_data is updated.
REQ-015 SHALL have port err  output  1  sticky timeout flag; present only with MD_DISPATCH_TIMEOUT_EN.

Function
REQ-016 SHALL implement a state machine with states IDLE, ISSUE and WAIT.
REQ-017 SHALL set in_ready = (state==IDLE) && !req and SHALL drive stall = in_valid && !in_ready, combinationally.
REQ-018 SHALL accept when in_valid && in_ready && in_op!=0: register in_op/in_rs/in_rt onto md_op/md_rs/md_rt and go to ISSUE.
REQ-019 SHALL treat in_valid with in_op==0 as a no-op: stay in IDLE, stall low.
REQ-020 SHALL drive md_op==0 in every state except ISSUE, so each operation reaches the unit for exactly one cycle.
REQ-021 ISSUE with req high SHALL drop the operation, go to IDLE and produce no rd_valid.
REQ-022 ISSUE with req low and start op (1-4) SHALL go to WAIT.
REQ-023 ISSUE with req low and mflo/mfhi SHALL capture md_out into rd_data, pulse rd_valid the next cycle and go to IDLE.
REQ-024 ISSUE with req low and mtlo/mthi SHALL go to IDLE.
REQ-025 WAIT SHALL go to IDLE at the first edge where md_busy==0 and req==0.
REQ-026 WAIT SHALL hold while req is high, because the unit's counter is frozen.
REQ-027 SHALL never use md_busy to form md_op, avoiding a combinational loop.
REQ-028 An operation held by stall SHALL be accepted in the first cycle the dispatcher is back in IDLE.

Reset
REQ-029 On rst, at the next edge, SHALL set state=IDLE, md_op=0, md_rs=0, md_rt=0, rd_data=0, rd_valid=0, err=0 and the WAIT counter to 0.
REQ-030 SHALL let rst override req and any in-flight state, including mid-WAIT.
REQ-031 After rst, stall SHALL be low in the first cycle after reset.

Configuration
REQ-032 With macro MD_DISPATCH_TIMEOUT_EN defined, SHALL count consecutive WAIT cycles with req low; on reaching WAIT_LIMIT it SHALL set err (sticky until rst) and force IDLE.
REQ-033 Without MD_DISPATCH_TIMEOUT_EN, SHALL omit err and the counter, and WAIT SHALL exit only per REQ-025.

Verification
REQ-034 Accept mult rs=3 rt=-2 at T: md_op=1 in T+1 only, WAIT T+2..T+7 with unit model, IDLE T+8, and a following mflo returns rd_data=0xFFFFFFFA.
REQ-035 Accept divu rs=7 rt=2: WAIT lasts 11 cycles, then mfhi returns rd_data=1 with a single rd_valid pulse.
REQ-036 Hold in_valid with mflo during a div: stall stays high throughout WAIT, and mflo issues exactly once, in the cycle after IDLE.
REQ-037 Raise req in the ISSUE cycle of mthi 0x55: md_op is 0 next cycle, HI is unchanged, state is IDLE, rd_valid=0.
REQ-038 Assert rst mid-WAIT: next cycle state=IDLE, stall=0, md_op=0, rd_data=0.
REQ-039 With MD_DISPATCH_TIMEOUT_EN and md_busy tied high after a mult: err=1 after exactly 16 WAIT cycles, state IDLE, err sticky until rst.

Source files
------------

// File: rtl/md_dispatch.sv
// -----------------------------------------------------------------------------
// md_dispatch
// Hands multiply/divide operations from the pipeline to the multiply-divide
// unit, one operation at a time. Each operation is shown to the unit for exactly
// one cycle. The block then waits for the unit to finish and captures HI/LO
// reads for the pipeline.
//
// Optional feature: define MD_DISPATCH_TIMEOUT_EN to add a WAIT watchdog. It
// sets the sticky err output and forces IDLE after WAIT_LIMIT counted WAIT
// cycles. A WAIT cycle is counted only while req is low.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req               exception/interrupt flush (unit commits nothing while high)
//   in_valid, in_op   pipeline MD operation request (op 0 = none)
//   in_rs, in_rt      operands
//   stall             pipeline must hold its MD instruction (combinational)
//   md_op/md_rs/md_rt registered operation and operands to the unit
//   md_busy           unit busy (counter running or start op on md_op)
//   md_out            unit HI/LO read data, combinational from md_op
//   rd_data, rd_valid captured mflo/mfhi result and its one-cycle strobe
//   err               sticky timeout flag (MD_DISPATCH_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module md_dispatch #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic        stall,
    output logic [3:0]  md_op,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt,
    input  logic        md_busy,
    input  logic [31:0] md_out,
    output logic [31:0] rd_data,
    output logic        rd_valid
`ifdef MD_DISPATCH_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_MULT = 4'd1;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MFLO = 4'd5;
    localparam logic [3:0] OP_MFHI = 4'd6;

    // A zero limit would time out before the unit can ever finish.
    if (WAIT_LIMIT == 0) begin : g_limit_check
        $error("md_dispatch: WAIT_LIMIT must be at least 1");
    end

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       in_ready;
    logic       accept;
    logic       md_start;
    logic       md_read;
    logic       capture;

`ifdef MD_DISPATCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
`endif

    // Next-state and handshake decode. md_busy only steers the state, never md_op.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
`ifdef MD_DISPATCH_TIMEOUT_EN
        timeout  = 1'b0;
`endif
        in_ready = (state == IDLE) && !req;
        stall    = in_valid && !in_ready;
        accept   = in_valid && in_ready && (in_op != OP_NONE);
        md_start = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
        md_read  = (md_op == OP_MFLO) || (md_op == OP_MFHI);

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                // The flush drops the op: the unit saw req high and committed nothing.
                if (req) begin
                    state_nx = IDLE;
                end else if (md_start) begin
                    state_nx = WAIT;
                end else begin
                    capture  = md_read;
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                // The unit counter is frozen while req is high, so WAIT holds as well.
                if (!req) begin
                    if (!md_busy) begin
                        state_nx = IDLE;
                    end
`ifdef MD_DISPATCH_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                        timeout  = 1'b1;
                        state_nx = IDLE;
                    end
`endif
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Unit-side registers. md_op is only nonzero for the single ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_op    <= OP_NONE;
            md_rs    <= 32'd0;
            md_rt    <= 32'd0;
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            md_op    <= accept ? in_op : OP_NONE;
            rd_valid <= capture;
            if (accept) begin
                md_rs <= in_rs;
                md_rt <= in_rt;
            end
            if (capture) begin
                rd_data <= md_out;
            end
        end
    end

`ifdef MD_DISPATCH_TIMEOUT_EN
    // WAIT watchdog: counts WAIT cycles with req low and clears outside WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (!req) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_md_dispatch.sv
// -----------------------------------------------------------------------------
// tb_md_dispatch
// Self-checking bench for md_dispatch. It contains a behavioural
// multiply-divide unit, a table of operations with their expected results and
// dispatch times, and a monitor. The monitor checks every md_op issue and every
// rd_valid result against scoreboard queues that are filled when stimulus is
// driven.
// -----------------------------------------------------------------------------
module tb_md_dispatch;

    localparam int unsigned LAT_MULT = 5;
    localparam int unsigned LAT_DIV  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic        stall;
    logic [3:0]  md_op;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        md_busy;
    logic [31:0] md_out;
    logic [31:0] rd_data;
    logic        rd_valid;
`ifdef MD_DISPATCH_TIMEOUT_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    md_dispatch #(.WAIT_LIMIT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .stall    (stall),
        .md_op    (md_op),
        .md_rs    (md_rs),
        .md_rt    (md_rt),
        .md_busy  (md_busy),
        .md_out   (md_out),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef MD_DISPATCH_TIMEOUT_EN
        ,
        .err      (err)
`endif
    );

    // ---------------- behavioural multiply-divide unit ----------------
    logic [31:0] u_hi;
    logic [31:0] u_lo;
    logic [3:0]  u_cnt;
    logic        force_busy;

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = $signed({{32{x[31]}}, x});
        b = $signed({{32{y[31]}}, y});
        return 64'(a * b);
    endfunction

    function automatic logic [63:0] sdiv(input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (y == 32'd0) return 64'd0;
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
    endfunction

    assign md_busy = force_busy || (u_cnt != 4'd0) || ((md_op >= 4'd1) && (md_op <= 4'd4));
    assign md_out  = (md_op == 4'd6) ? u_hi : u_lo;

    always @(posedge clk) begin
        if (rst) begin
            u_hi  <= 32'd0;
            u_lo  <= 32'd0;
            u_cnt <= 4'd0;
        end else if (!req) begin
            if (u_cnt != 4'd0) u_cnt <= u_cnt - 4'd1;
            case (md_op)
                4'd1: begin {u_hi, u_lo} <= smul(md_rs, md_rt); u_cnt <= 4'(LAT_MULT); end
                4'd2: begin {u_hi, u_lo} <= {32'd0, md_rs} * {32'd0, md_rt}; u_cnt <= 4'(LAT_MULT); end
                4'd3: begin {u_hi, u_lo} <= sdiv(md_rs, md_rt); u_cnt <= 4'(LAT_DIV); end
                4'd4: begin
                    if (md_rt != 32'd0) begin
                        u_lo <= md_rs / md_rt;
                        u_hi <= md_rs % md_rt;
                    end
                    u_cnt <= 4'(LAT_DIV);
                end
                4'd7: u_lo <= md_rs;
                4'd8: u_hi <= md_rs;
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
    } opr_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_rd;
        int          exp_cycles;  // ISSUE + WAIT cycles until back in IDLE
    } vec_t;

    opr_t        opq[$];
    logic [31:0] rdq[$];
    int          checks = 0;
    int          errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Present an op and hold it until accepted. Returns the number of stalled
    // cycles; on return the op is in ISSUE.
    task automatic accept(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp, output int n);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        #1;
        n = 0;
        while (stall && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_bound", 64'(stall), 64'd0);
        opq.push_back('{op, rs, rt});
        if (op == 4'd5 || op == 4'd6) rdq.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 4'd0;
    endtask

    // Probe the state with a no-op request: stall is high until the dispatcher is idle.
    task automatic wait_idle(output int n);
        in_valid = 1'b1;
        in_op    = 4'd0;
        #1;
        n = 0;
        while (stall && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_bound", 64'(stall), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp, output int n);
        int s;
        accept(op, rs, rt, exp, s);
        wait_idle(n);
    endtask

    vec_t vecs[16];

    initial begin
        int n;
        int w;
        opr_t e;

        vecs[0]  = '{4'd1, 32'd3,          32'hFFFF_FFFE, 32'd0,          7};
        vecs[1]  = '{4'd5, 32'd0,          32'd0,         32'hFFFF_FFFA,  1};
        vecs[2]  = '{4'd6, 32'd0,          32'd0,         32'hFFFF_FFFF,  1};
        vecs[3]  = '{4'd2, 32'hFFFF_FFFF,  32'd2,         32'd0,          7};
        vecs[4]  = '{4'd6, 32'd0,          32'd0,         32'd1,          1};
        vecs[5]  = '{4'd5, 32'd0,          32'd0,         32'hFFFF_FFFE,  1};
        vecs[6]  = '{4'd3, 32'hFFFF_FFF9,  32'd2,         32'd0,          12};
        vecs[7]  = '{4'd5, 32'd0,          32'd0,         32'hFFFF_FFFD,  1};
        vecs[8]  = '{4'd6, 32'd0,          32'd0,         32'hFFFF_FFFF,  1};
        vecs[9]  = '{4'd4, 32'd7,          32'd2,         32'd0,          12};
        vecs[10] = '{4'd6, 32'd0,          32'd0,         32'd1,          1};
        vecs[11] = '{4'd5, 32'd0,          32'd0,         32'd3,          1};
        vecs[12] = '{4'd7, 32'h0000_1234,  32'd0,         32'd0,          1};
        vecs[13] = '{4'd5, 32'd0,          32'd0,         32'h0000_1234,  1};
        vecs[14] = '{4'd8, 32'h0000_ABCD,  32'd0,         32'd0,          1};
        vecs[15] = '{4'd6, 32'd0,          32'd0,         32'h0000_ABCD,  1};

        // Reset with a live request on the inputs: reset must win.
        rst        = 1'b1;
        req        = 1'b0;
        force_busy = 1'b0;
        in_valid   = 1'b1;
        in_op      = 4'd1;
        in_rs      = 32'hDEAD_BEEF;
        in_rt      = 32'h1234_5678;

        // The monitor checks every unit issue and every read result.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (md_op != 4'd0) begin
                        if (opq.size() == 0) begin
                            check("md_op_spurious", 64'(md_op), 64'd0);
                        end else begin
                            e = opq.pop_front();
                            check("md_op", 64'(md_op), 64'(e.op));
                            check("md_rs", 64'(md_rs), 64'(e.rs));
                            check("md_rt", 64'(md_rt), 64'(e.rt));
                        end
                    end
                    if (rd_valid) begin
                        if (rdq.size() == 0) check("rd_valid_spurious", 64'(rd_valid), 64'd0);
                        else                 check("rd_data", 64'(rd_data), 64'(rdq.pop_front()));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_md_op",    64'(md_op),    64'd0);
        check("rst_md_rs",    64'(md_rs),    64'd0);
        check("rst_md_rt",    64'(md_rt),    64'd0);
        check("rst_rd_data",  64'(rd_data),  64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
`ifdef MD_DISPATCH_TIMEOUT_EN
        check("rst_err",      64'(err),      64'd0);
`endif
        in_op = 4'd0;
        rst   = 1'b0;
        #1;
        check("post_rst_stall", 64'(stall), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Table-driven operations: results go through the scoreboard, timing is checked here.
        for (int i = 0; i < 16; i++) begin
            accept(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_rd, n);
            check($sformatf("vec%0d_accept_delay", i), 64'(n), 64'd0);
            wait_idle(w);
            check($sformatf("vec%0d_busy_cycles", i), 64'(w), 64'(vecs[i].exp_cycles));
        end

        // A mflo held behind a div is stalled through WAIT and issued in the first idle cycle.
        accept(4'd3, 32'd100, 32'hFFFF_FFF9, 32'd0, n);
        accept(4'd5, 32'd0, 32'd0, 32'hFFFF_FFF2, n);
        check("held_mflo_stall_cycles", 64'(n), 64'd12);
        wait_idle(w);
        check("held_mflo_busy_cycles", 64'(w), 64'd1);
        do_op(4'd6, 32'd0, 32'd0, 32'd2, w);

        // req during WAIT freezes the unit, so WAIT is stretched by the req cycles.
        accept(4'd4, 32'd7, 32'd2, 32'd0, n);
        in_valid = 1'b1;
        in_op    = 4'd0;
        #1;
        w = 0;
        while (stall && w < 200) begin
            @(posedge clk); #1;
            w++;
            if (w == 2) req = 1'b1;
            if (w == 5) req = 1'b0;
        end
        in_valid = 1'b0;
        req      = 1'b0;
        check("req_wait_cycles", 64'(w), 64'd15);
        do_op(4'd6, 32'd0, 32'd0, 32'd1, w);

        // Flush in the ISSUE cycle of mthi: the op is dropped and HI is unchanged.
        do_op(4'd8, 32'h77, 32'd0, 32'd0, w);
        accept(4'd8, 32'h55, 32'd0, 32'd0, n);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("flush_md_op",    64'(md_op),    64'd0);
        check("flush_rd_valid", 64'(rd_valid), 64'd0);
        in_valid = 1'b1;
        in_op    = 4'd0;
        #1;
        check("flush_idle_stall", 64'(stall), 64'd0);
        in_valid = 1'b0;
        do_op(4'd6, 32'd0, 32'd0, 32'h77, w);

        // Reset while a div is in WAIT.
        accept(4'd3, 32'd50, 32'd5, 32'd0, n);
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_op    = 4'd0;
        #1;
        check("pre_rst_wait_stall", 64'(stall), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midwait_rst_md_op",    64'(md_op),    64'd0);
        check("midwait_rst_rd_data",  64'(rd_data),  64'd0);
        check("midwait_rst_rd_valid", 64'(rd_valid), 64'd0);
        check("midwait_rst_stall",    64'(stall),    64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        do_op(4'd7, 32'h0BAD_F00D, 32'd0, 32'd0, w);
        do_op(4'd5, 32'd0, 32'd0, 32'h0BAD_F00D, w);

`ifdef MD_DISPATCH_TIMEOUT_EN
        // Unit stuck busy: timeout after 16 WAIT cycles, err sticky until reset.
        force_busy = 1'b1;
        accept(4'd1, 32'd1, 32'd1, 32'd0, n);
        wait_idle(w);
        force_busy = 1'b0;
        check("timeout_cycles", 64'(w), 64'd17);
        check("timeout_err",    64'(err), 64'd1);
        do_op(4'd5, 32'd0, 32'd0, 32'd1, w);
        check("err_sticky",     64'(err), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("err_cleared",    64'(err), 64'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("op_queue_drained", 64'(opq.size()), 64'd0);
        check("rd_queue_drained", 64'(rdq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
